// File: rtl/unpack_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one data_unpack input between NUM_SRC sources.
// A grant is held from the sop word through the eop word; framing errors are flagged per source.
module unpack_pkt_arbiter #(
    parameter int  NUM_SRC = 4,
    parameter int  DATA_W  = 32,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        s_valid,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    input  logic [NUM_SRC-1:0]        s_sop,
    input  logic [NUM_SRC-1:0]        s_eop,
    output logic [NUM_SRC-1:0]        s_ready,
    output logic                      m_valid,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_sop,
    output logic                      m_eop,
    input  logic                      m_ready,
    output logic                      grant_valid,
    output logic [SRC_W-1:0]          grant_id,
    output logic [NUM_SRC-1:0]        err,
    input  logic [NUM_SRC-1:0]        err_clr
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     grant_id_q, grant_id_d;
    logic [SRC_W-1:0]     last_q, last_d;
    logic [NUM_SRC-1:0]   err_q, err_d;
    logic [NUM_SRC-1:0]   err_set_s;
    logic                 first_q, first_d;
    logic                 found_s;
    logic [SRC_W-1:0]     winner_s;
    logic                 xfer_s;

    // Round-robin search over sop-carrying sources, starting just after the last finished one
    always_comb begin
        int idx;
        found_s  = 1'b0;
        winner_s = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_q) + k) % NUM_SRC;
            if (!found_s && s_valid[idx] && s_sop[idx]) begin
                found_s  = 1'b1;
                winner_s = SRC_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Datapath mux and ready routing; while idle, stray non-sop words are drained
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        s_ready = '0;
        xfer_s  = 1'b0;
        if (state_q == ST_LOCKED) begin
            m_valid             = s_valid[grant_id_q];
            m_sop               = s_sop[grant_id_q];
            m_eop               = s_eop[grant_id_q];
            m_data              = s_valid[grant_id_q] ?
                                  s_data[int'(grant_id_q)*DATA_W +: DATA_W] : '0;
            s_ready[grant_id_q] = m_ready;
            xfer_s              = s_valid[grant_id_q] & m_ready;
        end else begin
            // gated by rst so nothing is accepted while the unpacker is held in reset
            s_ready = s_valid & ~s_sop & {NUM_SRC{rst}};
        end
    end

    // Next-state: lock on a winner, release on the eop transfer, collect framing errors
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        first_d    = first_q;
        err_set_s  = '0;
        case (state_q)
            ST_IDLE: begin
                err_set_s = s_valid & ~s_sop;
                if (found_s) begin
                    state_d    = ST_LOCKED;
                    grant_id_d = winner_s;
                    first_d    = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s) begin
                    first_d = 1'b0;
                    if (m_sop && !first_q) begin
                        err_set_s[grant_id_q] = 1'b1;
                    end else begin
                        err_set_s = '0;
                    end
                    if (m_eop) begin
                        state_d = ST_IDLE;
                        last_d  = grant_id_q;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        err_d = err_set_s | (err_q & ~err_clr);
    end

    // State and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            last_q     <= SRC_W'(NUM_SRC - 1);
            err_q      <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

    assign grant_valid = (state_q == ST_LOCKED);
    assign grant_id    = grant_id_q;
    assign err         = err_q;

endmodule
